seq_restoring_divider: RTL and testbench

//   Multi-cycle unsigned restoring divider: dividend / divisor -> quotient, remainder.

---
 rtl/seq_restoring_divider.sv | 256 +++++++++++++++++++++++++
 tb/tb_seq_restoring_divider.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// ----------------------------------------------------------------------------
// seq_restoring_divider
//
// Purpose:
//   Multi-cycle unsigned restoring divider. It computes
//   dividend / divisor -> quotient, remainder and retires one quotient bit per
//   clock. Each iteration's trial subtraction (rem - divisor) is done as
//   rem + ~divisor + 1 through a carry-skip adder. The adder's carry-out is
//   the "no borrow" flag that selects between the difference and the restored
//   partial remainder.
//
// Handshake:
//   The block accepts a request in any cycle where start=1 and busy=0, that is
//   in IDLE or in the one-cycle DONE state. A start while busy=1 is ignored.
//   done is a one-cycle pulse. quotient, remainder and div_by_zero are valid
//   from that pulse and stay unchanged until a new request is accepted.
//
// Parameters:
//   WIDTH       operand and result width in bits (4..16)
//   SKIP_BLOCK  bits per carry-skip block in the trial subtractor; the top
//               block may be partial
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   request, accepted only while busy=0
//   dividend     in   numerator, sampled on accept
//   divisor      in   denominator, sampled on accept
//   busy         out  high while iterating (state RUN)
//   done         out  one-cycle pulse, results valid
//   quotient     out  result quotient, held until the next accept
//   remainder    out  result remainder, held until the next accept
//   div_by_zero  out  set together with done when divisor==0
//
// Latency, counting the accept cycle as cycle 0:
//   done is high in cycle WIDTH+1 for a normal division.
//   done is high in cycle 1 when dividing by zero.
// ----------------------------------------------------------------------------
module seq_restoring_divider #(
    parameter int WIDTH      = 8,
    parameter int SKIP_BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // Trial-subtraction width: the partial remainder plus the incoming bit.
    localparam int N  = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // FSM state. It is kept as a named enum so that hierarchical checkers can
    // observe it directly.
    state_t state_q;
    state_t state_n;

    // Datapath registers
    logic [WIDTH-1:0] rem_q;    // partial remainder
    logic [WIDTH-1:0] q_q;      // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] div_q;    // latched divisor
    logic [CW-1:0]    cnt_q;    // iterations still to run

    // Control decode
    logic accept;       // request taken this cycle
    logic accept_zero;  // request taken with divisor==0
    logic last_iter;    // this RUN cycle performs the final iteration

    // Trial subtractor signals
    logic [N-1:0]     add_a;    // t = {rem, q msb}
    logic [N-1:0]     add_b;    // ~{0, divisor}
    logic [WIDTH-1:0] add_sum;  // low WIDTH bits of t - divisor
    logic             add_cout; // 1 = no borrow, t >= divisor

    // Next-iteration values
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;

    // Registered-output next values (output decode process)
    logic busy_d;
    logic done_d;
    logic load_zero;    // divide-by-zero results on the edge into DONE
    logic load_result;  // iteration results on the edge into DONE
    logic clear_flag;   // normal accept clears div_by_zero

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    // Requests are accepted whenever the core is not iterating. DONE counts
    // as not busy, so a start during the result cycle runs back-to-back.
    assign accept      = start && (state_q != ST_RUN);
    assign accept_zero = accept && (divisor == '0);
    assign last_iter   = (state_q == ST_RUN) && (cnt_q == CW'(1));

    // ------------------------------------------------------------------------
    // FSM process 1 of 3: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 2 of 3: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    // A zero divisor skips RUN and reports on the next edge.
                    state_n = (divisor == '0) ? ST_DONE : ST_RUN;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_iter) begin
                    state_n = ST_DONE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM process 3 of 3: output decode
    // ------------------------------------------------------------------------
    // Every output is a register. This process works out what each register
    // takes on the coming edge, using the next state, so that busy and done
    // line up with the state they describe.
    always_comb begin
        busy_d      = (state_n == ST_RUN);
        done_d      = (state_n == ST_DONE);
        load_zero   = accept_zero;
        load_result = last_iter;
        clear_flag  = accept && !accept_zero;
    end

    // ------------------------------------------------------------------------
    // Carry-skip trial subtractor: d = t + ~{0,divisor} + 1
    // ------------------------------------------------------------------------
    assign add_a = {rem_q, q_q[WIDTH-1]};
    assign add_b = ~{1'b0, div_q};

    // The carry ripples bit by bit inside a block. At the end of each block
    // the carry handed to the next block is the block's own carry-in whenever
    // every bit propagates (a^b all ones); otherwise it is the rippled carry.
    // Both choices are logically equal, so the sum matches plain subtraction.
    // Only the carry-out is needed from the top bit; the top sum bit is always
    // 0 when the difference is kept (t < 2*divisor), so it is not stored.
    always_comb begin
        logic c;
        logic blk_cin;
        logic blk_p;
        logic pi;
        c       = 1'b1;   // +1 of the two's-complement negation
        blk_cin = 1'b1;
        blk_p   = 1'b1;
        pi      = 1'b0;
        add_sum = '0;
        for (int i = 0; i < N; i++) begin
            if ((i % SKIP_BLOCK) == 0) begin
                blk_cin = c;
                blk_p   = 1'b1;
            end
            pi = add_a[i] ^ add_b[i];
            if (i < WIDTH) begin
                add_sum[i] = pi ^ c;
            end
            blk_p = blk_p & pi;
            c     = (add_a[i] & add_b[i]) | (c & pi);
            if (((i % SKIP_BLOCK) == (SKIP_BLOCK - 1)) || (i == N - 1)) begin
                c = blk_p ? blk_cin : c;
            end
        end
        add_cout = c;
    end

    // Restoring step: keep the difference on no-borrow, otherwise keep t.
    always_comb begin
        rem_next = add_cout ? add_sum : add_a[WIDTH-1:0];
        q_next   = {q_q[WIDTH-2:0], add_cout};
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    // The operand registers load only on accept, so a start while busy leaves
    // an in-flight division untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            q_q   <= '0;
            div_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            rem_q <= '0;
            q_q   <= dividend;
            div_q <= divisor;
            cnt_q <= CW'(WIDTH);
        end else if (state_q == ST_RUN) begin
            rem_q <= rem_next;
            q_q   <= q_next;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_d;
            done <= done_d;
        end
    end

    // Results change only on the edge into DONE. A normal accept clears
    // div_by_zero but leaves quotient and remainder holding the last results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (load_zero) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
        end else if (load_result) begin
            quotient    <= q_next;
            remainder   <= rem_next;
        end else if (clear_flag) begin
            div_by_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// ----------------------------------------------------------------------------
// tb_seq_restoring_divider
//
// Drives two instances of the divider: WIDTH=8/SKIP_BLOCK=4 and
// WIDTH=13/SKIP_BLOCK=3. The bench has four parts:
//   - a table of directed vectors with hand-computed results and latency
//   - hand-written sequences for the multi-cycle corner cases: a start while
//     busy, a start during DONE, and a reset in the middle of a division
//   - a pseudo-random sweep on each instance, checked against / and %
//   - a final report line
// ----------------------------------------------------------------------------
module tb_seq_restoring_divider;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // WIDTH=8 instance signals
  logic        start8;
  logic [7:0]  dvd8, dvs8;
  logic        busy8, done8, z8;
  logic [7:0]  q8, r8;

  // WIDTH=13 instance signals
  logic        start13;
  logic [12:0] dvd13, dvs13;
  logic        busy13, done13, z13;
  logic [12:0] q13, r13;

  seq_restoring_divider #(.WIDTH(8), .SKIP_BLOCK(4)) u_dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start8),
    .dividend    (dvd8),
    .divisor     (dvs8),
    .busy        (busy8),
    .done        (done8),
    .quotient    (q8),
    .remainder   (r8),
    .div_by_zero (z8)
  );

  seq_restoring_divider #(.WIDTH(13), .SKIP_BLOCK(3)) u_dut13 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start13),
    .dividend    (dvd13),
    .divisor     (dvs13),
    .busy        (busy13),
    .done        (done13),
    .quotient    (q13),
    .remainder   (r13),
    .div_by_zero (z13)
  );

  // --------------------------------------------------------------------------
  // Scoreboard state
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];   // expected {quotient, remainder} for the random sweep

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  // All inputs change 1 time unit after the rising edge, and outputs are
  // sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic st, input logic [15:0] a, input logic [15:0] b);
    if (sel == 0) begin
      start8 = st;
      dvd8   = a[7:0];
      dvs8   = b[7:0];
    end else begin
      start13 = st;
      dvd13   = a[12:0];
      dvs13   = b[12:0];
    end
  endtask

  task automatic set_start(input int sel, input logic st);
    if (sel == 0) start8 = st;
    else          start13 = st;
  endtask

  // Issue one division in the current cycle (cycle 0), then wait for done
  // within a cycle budget. The task returns in the cycle where done is high,
  // or with lat=-1 if the budget runs out. If poke_cyc >= 0, a second start
  // carrying operands pa/pb is driven in that cycle. It is meant to be ignored.
  task automatic do_div(input int sel, input logic [15:0] a, input logic [15:0] b,
                        input int poke_cyc, input logic [15:0] pa, input logic [15:0] pb,
                        output logic [15:0] q, output logic [15:0] r, output logic z,
                        output int lat, output logic busy_seen);
    int cyc;
    lat = -1;
    busy_seen = 1'b0;
    q = '0;
    r = '0;
    z = 1'b0;
    drive(sel, 1'b1, a, b);
    tick();
    cyc = 1;
    while (cyc < 40) begin
      if (cyc == poke_cyc) drive(sel, 1'b1, pa, pb);
      else                 set_start(sel, 1'b0);
      if ((sel == 0) ? busy8 : busy13) busy_seen = 1'b1;
      if ((sel == 0) ? done8 : done13) begin
        lat = cyc;
        q = (sel == 0) ? {8'd0, q8} : {3'd0, q13};
        r = (sel == 0) ? {8'd0, r8} : {3'd0, r13};
        z = (sel == 0) ? z8 : z13;
        break;
      end
      tick();
      cyc++;
    end
    set_start(sel, 1'b0);
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table (WIDTH=8)
  // --------------------------------------------------------------------------
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [15:0] rq, rr;
    logic        rz, rbusy;
    int          rlat;
    int          done_cnt;
    logic [15:0] ra, rb, eq, er;

    // Hand-computed vectors: {dividend, divisor, quotient, remainder, dbz, latency}
    vecs[0]  = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 9};
    vecs[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9};
    vecs[2]  = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 9};
    vecs[3]  = '{8'd13,  8'd0,   8'hFF,  8'd13,  1'b1, 1};
    vecs[4]  = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 9};
    vecs[5]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 9};
    vecs[6]  = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0, 9};
    vecs[7]  = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0, 9};
    vecs[8]  = '{8'd7,   8'd7,   8'd1,   8'd0,   1'b0, 9};
    vecs[9]  = '{8'd1,   8'd0,   8'hFF,  8'd1,   1'b1, 1};
    vecs[10] = '{8'd99,  8'd10,  8'd9,   8'd9,   1'b0, 9};
    vecs[11] = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1, 1};

    // Reset
    start8 = 1'b0; dvd8 = '0; dvs8 = '0;
    start13 = 1'b0; dvd13 = '0; dvs13 = '0;
    rst_n = 1'b0;
    tick();
    tick();
    check("reset_busy",   32'(busy8), 32'd0);
    check("reset_done",   32'(done8), 32'd0);
    check("reset_quot",   32'(q8),    32'd0);
    check("reset_rem",    32'(r8),    32'd0);
    check("reset_dbz",    32'(z8),    32'd0);
    rst_n = 1'b1;
    tick();

    // Directed table
    for (int i = 0; i < 12; i++) begin
      do_div(0, {8'd0, vecs[i].a}, {8'd0, vecs[i].b}, -1, 16'd0, 16'd0, rq, rr, rz, rlat, rbusy);
      check($sformatf("vec%0d_latency", i), 32'(rlat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_quot", i), 32'(rq), 32'(vecs[i].q));
      check($sformatf("vec%0d_rem", i), 32'(rr), 32'(vecs[i].r));
      check($sformatf("vec%0d_dbz", i), 32'(rz), 32'(vecs[i].z));
      check($sformatf("vec%0d_busy_seen", i), 32'(rbusy), 32'(!vecs[i].z));
      check($sformatf("vec%0d_busy_at_done", i), 32'(busy8), 32'd0);
      tick();
      check($sformatf("vec%0d_done_pulse", i), 32'(done8), 32'd0);
      check($sformatf("vec%0d_quot_held", i), 32'(q8), 32'(vecs[i].q));
      check($sformatf("vec%0d_dbz_held", i), 32'(z8), 32'(vecs[i].z));
    end

    // A start while busy is ignored: 100/3, with 50/5 offered in cycle 4
    do_div(0, 16'd100, 16'd3, 4, 16'd50, 16'd5, rq, rr, rz, rlat, rbusy);
    check("ignore_latency", 32'(rlat), 32'd9);
    check("ignore_quot",    32'(rq),   32'd33);
    check("ignore_rem",     32'(rr),   32'd1);

    // Back-to-back: start 9/4 in the DONE cycle of the previous division
    do_div(0, 16'd9, 16'd4, -1, 16'd0, 16'd0, rq, rr, rz, rlat, rbusy);
    check("b2b_latency", 32'(rlat), 32'd9);
    check("b2b_quot",    32'(rq),   32'd2);
    check("b2b_rem",     32'(rr),   32'd1);
    check("b2b_dbz",     32'(rz),   32'd0);
    tick();

    // Reset in cycle 5 of 200/7 takes effect at once and produces no done
    drive(0, 1'b1, 16'd200, 16'd7);
    tick();
    set_start(0, 1'b0);
    tick(); tick(); tick(); tick();
    check("midreset_busy_before", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", 32'(busy8), 32'd0);
    check("midreset_done", 32'(done8), 32'd0);
    check("midreset_quot", 32'(q8),    32'd0);
    check("midreset_rem",  32'(r8),    32'd0);
    check("midreset_dbz",  32'(z8),    32'd0);
    tick();
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done8) done_cnt++;
    end
    check("midreset_no_done", 32'(done_cnt), 32'd0);
    do_div(0, 16'd17, 16'd5, -1, 16'd0, 16'd0, rq, rr, rz, rlat, rbusy);
    check("after_reset_latency", 32'(rlat), 32'd9);
    check("after_reset_quot",    32'(rq),   32'd3);
    check("after_reset_rem",     32'(rr),   32'd2);
    tick();

    // WIDTH=13 directed: latency is WIDTH+1 = 14
    do_div(1, 16'd8191, 16'd3, -1, 16'd0, 16'd0, rq, rr, rz, rlat, rbusy);
    check("w13_latency", 32'(rlat), 32'd14);
    check("w13_quot",    32'(rq),   32'd2730);
    check("w13_rem",     32'(rr),   32'd1);
    tick();
    do_div(1, 16'd5000, 16'd7, -1, 16'd0, 16'd0, rq, rr, rz, rlat, rbusy);
    check("w13_quot_b", 32'(rq), 32'd714);
    check("w13_rem_b",  32'(rr), 32'd2);
    tick();
    do_div(1, 16'd13, 16'd0, -1, 16'd0, 16'd0, rq, rr, rz, rlat, rbusy);
    check("w13_dbz_latency", 32'(rlat), 32'd1);
    check("w13_dbz_quot",    32'(rq),   32'h1FFF);
    check("w13_dbz_rem",     32'(rr),   32'd13);
    check("w13_dbz_flag",    32'(rz),   32'd1);
    tick();

    // Pseudo-random sweep on both instances against / and %
    for (int sel = 0; sel < 2; sel++) begin
      for (int n = 0; n < 150; n++) begin
        int maxv;
        maxv = (sel == 0) ? 255 : 8191;
        ra = 16'($urandom_range(0, maxv));
        if ((n % 16) == 0)     rb = 16'd0;
        else if ((n % 3) == 0) rb = 16'($urandom_range(1, 15));
        else                   rb = 16'($urandom_range(1, maxv));
        if (rb == 16'd0) begin
          eq = 16'(maxv);
          er = ra;
        end else begin
          eq = ra / rb;
          er = ra % rb;
        end
        exp_q.push_back({eq, er});
        do_div(sel, ra, rb, -1, 16'd0, 16'd0, rq, rr, rz, rlat, rbusy);
        check($sformatf("rand_w%0d_result_%0d_div_%0d", (sel == 0) ? 8 : 13, ra, rb),
              {rq, rr}, exp_q.pop_front());
        check($sformatf("rand_w%0d_dbz_%0d_div_%0d", (sel == 0) ? 8 : 13, ra, rb),
              32'(rz), 32'(rb == 16'd0));
        tick();
      end
    end

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
